// File: rtl/mmio_mailbox_pkg.sv
// Shared definitions for the MMIO mailbox: register offsets, STATUS layout
// and the default window base address.
package mmio_mailbox_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'h0000_1000;

  // Word offsets inside the 16-byte window, selected by mem_addr[3:2].
  typedef enum logic [1:0] {
    OFF_DATA   = 2'd0,
    OFF_STATUS = 2'd1,
    OFF_HALT   = 2'd2,
    OFF_RSVD   = 2'd3
  } offset_e;

  // STATUS register bit positions.
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_HALTED    = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_W   = 8;

  typedef struct packed {
    logic       empty;
    logic       full;
    logic       halted;
    logic       overflow;
    logic [7:0] count;
  } status_t;

  // Places the status fields at their architectural bit positions.
  function automatic logic [31:0] pack_status(input status_t s);
    logic [31:0] w;
    w                                = '0;
    w[ST_EMPTY]                      = s.empty;
    w[ST_FULL]                       = s.full;
    w[ST_HALTED]                     = s.halted;
    w[ST_OVERFLOW]                   = s.overflow;
    w[ST_COUNT_LSB +: ST_COUNT_W]    = s.count;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth. A push on a full FIFO is
// accepted only when a pop happens in the same cycle; head_data reads as
// zero while the FIFO is empty.
module sync_fifo
  import mmio_mailbox_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign do_pop    = pop & ~empty;
  // Full FIFO still takes the word when the head leaves in the same cycle.
  assign do_push   = push & (~full | do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage write port.
  // NOTE: the storage array has no reset; validity is tracked by count, so
  // clearing the RAM would only cost area and block RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values and the ordering of statements does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_mailbox.sv
// Memory-mapped mailbox beside data memory: DATA stores are queued and
// streamed out over valid/ready, HALT latches a sticky completion flag and
// code, STATUS exposes FIFO occupancy and flags.
module mmio_mailbox
  import mmio_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE  = DEFAULT_BASE,
  parameter int          DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        hit,
  output logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        halted,
  output logic [31:0] halt_code
);

  localparam int AW = $clog2(DEPTH);

  offset_e       offset;
  logic          data_wr;
  logic          halt_wr;
  logic          push_req;
  logic          pop_req;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          overflow;
  status_t       status;
  logic          unused_addr_bits;

  // Byte lanes inside a word are irrelevant: only word stores exist.
  assign unused_addr_bits = ^mem_addr[1:0];

  assign offset   = offset_e'(mem_addr[3:2]);
  assign hit      = (mem_addr[31:4] == BASE[31:4]);
  assign data_wr  = hit & mem_we & (offset == OFF_DATA);
  assign halt_wr  = hit & mem_we & (offset == OFF_HALT);
  // After halt the DATA register is dead: no push and no overflow.
  assign push_req = data_wr & ~halted;
  assign pop_req  = out_valid & out_ready;

  // out_valid follows the asynchronously reset count, so a reset flushes the
  // stream immediately rather than at the next edge.
  assign out_valid = ~fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (mem_wdata),
    .pop       (pop_req),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sticky halt flag/code and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted    <= 1'b0;
      halt_code <= '0;
      overflow  <= 1'b0;
    end else begin
      if (halt_wr) begin
        halted    <= 1'b1;
        halt_code <= mem_wdata;
      end
      if (push_req & fifo_full & ~pop_req) overflow <= 1'b1;
    end
  end

  // Register read mux; reads have no side effects.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    status          = '0;
    status.empty    = fifo_empty;
    status.full     = fifo_full;
    status.halted   = halted;
    status.overflow = overflow;
    status.count    = 8'(fifo_count);
    mem_rdata       = '0;
    if (hit) begin
      case (offset)
        OFF_STATUS: mem_rdata = pack_status(status);
        OFF_HALT:   mem_rdata = halt_code;
        default:    mem_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_mailbox.sv
// Self-checking bench for mmio_mailbox: a behavioural model tracks which
// stores are accepted and queues the words the consumer must see; a monitor
// compares the stream and flags against that model every cycle.
module tb_mmio_mailbox;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        hit;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        halted;
  logic [31:0] halt_code;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [31:0] sb_q[$];
  int          m_count = 0;
  bit          m_halted = 1'b0;
  bit          m_ovf = 1'b0;
  logic [31:0] m_code = '0;
  bit          m_pop;
  bit          m_in_win;
  int          m_off;

  mmio_mailbox #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .hit       (hit),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .halted    (halted),
    .halt_code (halt_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'(m_count) * 256;
    if (m_ovf)            s = s + 8;
    if (m_halted)         s = s + 4;
    if (m_count == DEPTH) s = s + 2;
    if (m_count == 0)     s = s + 1;
    return s;
  endfunction

  // Behavioural model: decides at each edge which stores are accepted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count  = 0;
      m_halted = 1'b0;
      m_ovf    = 1'b0;
      m_code   = '0;
      sb_q.delete();
    end else begin
      m_in_win = (mem_addr[31:4] == BASE[31:4]);
      m_off    = int'(mem_addr[3:2]);
      m_pop    = (m_count > 0) && out_ready;
      if (mem_we && m_in_win && m_off == 0 && !m_halted) begin
        if (m_count == DEPTH && !m_pop) m_ovf = 1'b1;
        else begin
          sb_q.push_back(mem_wdata);
          m_count++;
        end
      end
      if (m_pop) m_count--;
      if (mem_we && m_in_win && m_off == 2) begin
        m_halted = 1'b1;
        m_code   = mem_wdata;
      end
    end
  end

  // Monitor: compares the stream head and flags mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, sb_q.size() != 0});
      check("halted", {31'b0, halted}, {31'b0, m_halted});
      check("halt_code", halt_code, m_code);
      if (out_valid && sb_q.size() != 0) begin
        check("out_data", out_data, sb_q[0]);
        if (out_ready) void'(sb_q.pop_front());
      end else if (!out_valid) begin
        check("out_data_idle", out_data, 32'h0);
      end
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_we    = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    @(posedge clk);
    #1;
    mem_we    = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    mem_we   = 1'b0;
    mem_addr = a;
    #1;
    check(name, mem_rdata, exp);
  endtask

  task automatic idle(input int n);
    mem_we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;

    // Reset state.
    do_reset();
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_code", halt_code, 32'h0);
    read_chk("rst_status", BASE + 4, 32'h0000_0001);

    // Three stores with the consumer stalled.
    store(BASE, 32'd5);
    store(BASE, 32'd8);
    store(BASE, 32'd13);
    read_chk("status_3", BASE + 4, 32'h0000_0300);
    check("head_valid", {31'b0, out_valid}, 32'h1);
    check("head_data", out_data, 32'd5);

    // Drain them: the monitor checks 5, 8, 13 in order.
    out_ready = 1'b1;
    idle(3);
    out_ready = 1'b0;
    check("drained_valid", {31'b0, out_valid}, 32'h0);
    read_chk("drained_status", BASE + 4, 32'h0000_0001);

    // Nine stores into an eight-deep FIFO: the ninth is dropped.
    for (int i = 0; i < 9; i++) store(BASE, 32'd100 + 32'(i));
    read_chk("overflow_status", BASE + 4, 32'h0000_080A);

    // Store on a full FIFO while the head leaves: accepted, count stays 8.
    out_ready = 1'b1;
    store(BASE, 32'd200);
    out_ready = 1'b0;
    read_chk("full_pushpop_status", BASE + 4, 32'h0000_080A);
    check("full_head", out_data, 32'd101);

    // Drain fully; word 108 must never appear.
    out_ready = 1'b1;
    idle(DEPTH + 2);
    out_ready = 1'b0;
    read_chk("full_drained", BASE + 4, exp_status());

    // Randomized traffic across the window and outside it.
    for (int i = 0; i < 400; i++) begin
      r         = int'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) == 0);
      case (r)
        0, 1, 2: store(BASE | 32'($urandom_range(0, 3)), $urandom);
        3:       store(BASE + 4, $urandom);
        4:       store(BASE + 12, $urandom);
        5:       store(BASE + 32'h10 * 32'($urandom_range(1, 15)), $urandom);
        default: begin
          read_chk("rand_status", BASE + 4, exp_status());
          idle(1);
        end
      endcase
    end
    out_ready = 1'b1;
    idle(DEPTH + 2);
    out_ready = 1'b0;
    read_chk("rand_drained", BASE + 4, exp_status());

    // HALT: sticky flag and code, DATA stores ignored afterwards.
    store(BASE + 8, 32'h5);
    check("halt_flag", {31'b0, halted}, 32'h1);
    check("halt_code5", halt_code, 32'h5);
    read_chk("halt_read", BASE + 8, 32'h5);
    store(BASE, 32'd77);
    check("halt_no_push", {31'b0, out_valid}, 32'h0);
    read_chk("halt_status", BASE + 4, exp_status());
    store(BASE + 8, 32'h9);
    check("halt_again", {31'b0, halted}, 32'h1);
    read_chk("halt_read9", BASE + 8, 32'h9);

    // Reserved offset and out-of-window stores change nothing.
    a = exp_status();
    store(BASE + 12, 32'hDEAD_BEEF);
    store(BASE + 32'h10, 32'hCAFE_F00D);
    read_chk("rsvd_read", BASE + 12, 32'h0);
    check("rsvd_hit", {31'b0, hit}, 32'h1);
    read_chk("miss_read", BASE + 32'h10, 32'h0);
    check("miss_hit", {31'b0, hit}, 32'h0);
    read_chk("data_read", BASE, 32'h0);
    read_chk("rsvd_status", BASE + 4, a);
    check("rsvd_code", halt_code, 32'h9);

    // Asynchronous reset mid-drain with four entries queued.
    do_reset();
    for (int i = 0; i < 4; i++) store(BASE, 32'd300 + 32'(i));
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'b0, out_valid}, 32'h0);
    check("async_data", out_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b0;
    read_chk("post_rst_status", BASE + 4, 32'h0000_0001);
    check("post_rst_halted", {31'b0, halted}, 32'h0);
    check("post_rst_code", halt_code, 32'h0);
    check("post_rst_valid", {31'b0, out_valid}, 32'h0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
